// File: rtl/mul_rs_pkg.sv
// Shared configuration and types for the multiply reservation station.
// Optional feature: MUL_RS_AGE_EN selects oldest-ready issue (age matrix)
// instead of lowest-index issue.
package mul_rs_pkg;

  // ooo_config: machine sizing
  localparam int ENTRIES     = 4;
  localparam int PREG_BITS   = 6;
  localparam int ROB_BITS    = 5;
  localparam int NUM_BRU     = 4;
  localparam int CDB_PORTS   = 3;
  localparam int BR_IDX_BITS = $clog2(NUM_BRU);

  // rv32i_types: micro-op payload types
  typedef logic [PREG_BITS-1:0] preg_t;
  typedef logic [NUM_BRU-1:0]   br_mask_t;

  typedef enum logic [2:0] {
    MUL_F3_MUL    = 3'b000,
    MUL_F3_MULH   = 3'b001,
    MUL_F3_MULHSU = 3'b010,
    MUL_F3_MULHU  = 3'b011
  } mul_f3_t;

  typedef struct packed {
    logic                valid;
    preg_t               ps1;
    logic                ps1_rdy;
    preg_t               ps2;
    logic                ps2_rdy;
    preg_t               pd;
    logic [4:0]          rd;
    logic [ROB_BITS-1:0] rob_idx;
    mul_f3_t             mulop;
    br_mask_t            br_mask;
  } mul_rs_entry_t;

  // True when any valid CDB port broadcasts the given tag.
  function automatic logic cdb_hit(
    input preg_t                           tag,
    input logic [CDB_PORTS-1:0]            vld,
    input logic [CDB_PORTS*PREG_BITS-1:0]  pd
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < CDB_PORTS; p++)
      if (vld[p] && (pd[p*PREG_BITS +: PREG_BITS] == tag)) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/mul_rs_select.sv
// Issue picker: ready vector (plus age matrix when MUL_RS_AGE_EN) to a
// one-hot grant. Default build grants the lowest ready index.
module mul_rs_select
  import mul_rs_pkg::*;
(
  input  logic [ENTRIES-1:0]              req,
`ifdef MUL_RS_AGE_EN
  // age[i][j] = 1 means entry j is older than entry i
  input  logic [ENTRIES-1:0][ENTRIES-1:0] age,
`endif
  output logic [ENTRIES-1:0]              gnt,
  output logic                            gnt_valid
);

`ifdef MUL_RS_AGE_EN
  // Grant the requester that has no older requester.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < ENTRIES; i++)
      gnt[i] = req[i] & ~(|(req & age[i]));
  end
`else
  // Grant the lowest-index requester.
  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < ENTRIES; i++)
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
  end
`endif

  assign gnt_valid = |req;

endmodule

// File: rtl/mul_rs.sv
// Multiply reservation station: holds dispatched MUL-family uops, wakes
// sources from the CDB, issues one ready uop per cycle, squashes on
// branch mispredict. Optional MUL_RS_AGE_EN: oldest-ready issue.
module mul_rs
  import mul_rs_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_all,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [PREG_BITS-1:0]           disp_ps1,
  input  logic [PREG_BITS-1:0]           disp_ps2,
  input  logic                           disp_ps1_rdy,
  input  logic                           disp_ps2_rdy,
  input  logic [PREG_BITS-1:0]           disp_pd,
  input  logic [4:0]                     disp_rd,
  input  logic [ROB_BITS-1:0]            disp_rob_idx,
  input  logic [2:0]                     disp_mulop,
  input  logic [NUM_BRU-1:0]             disp_br_mask,
  input  logic [CDB_PORTS-1:0]           cdb_valid,
  input  logic [CDB_PORTS*PREG_BITS-1:0] cdb_pd,
  input  logic                           br_valid,
  input  logic                           br_mispred,
  input  logic [BR_IDX_BITS-1:0]         br_idx,
  output logic                           iss_valid,
  output logic [PREG_BITS-1:0]           iss_ps1,
  output logic [PREG_BITS-1:0]           iss_ps2,
  output logic [PREG_BITS-1:0]           iss_pd,
  output logic [4:0]                     iss_rd,
  output logic [ROB_BITS-1:0]            iss_rob_idx,
  output logic [2:0]                     iss_mulop,
  output logic [NUM_BRU-1:0]             iss_br_mask
);

  mul_rs_entry_t [ENTRIES-1:0] ent;
  mul_rs_entry_t               new_ent;

  logic [ENTRIES-1:0] vld, kill, req, gnt, free_oh;
  logic               any_free, gnt_valid, disp_kill, disp_we;
  br_mask_t           br_clr;

  // Bit of the resolving branch; cleared from surviving masks either way.
  always_comb begin
    br_clr = '0;
    if (br_valid) br_clr[br_idx] = 1'b1;
  end

  // Per-entry status from cycle-start state.
  always_comb begin
    vld  = '0;
    kill = '0;
    req  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      vld[i]  = ent[i].valid;
      kill[i] = br_valid & br_mispred & ent[i].br_mask[br_idx];
      req[i]  = ent[i].valid & ent[i].ps1_rdy & ent[i].ps2_rdy & ~kill[i];
    end
  end

  // Lowest free slot; a slot issuing this cycle still counts as occupied.
  always_comb begin
    free_oh  = '0;
    any_free = 1'b0;
    for (int i = 0; i < ENTRIES; i++)
      if (!vld[i] && !any_free) begin
        free_oh[i] = 1'b1;
        any_free   = 1'b1;
      end
  end

  assign disp_ready = rst | any_free;
  assign disp_kill  = br_valid & br_mispred & disp_br_mask[br_idx];
  assign disp_we    = disp_valid & any_free & ~disp_kill & ~flush_all;

  // Incoming entry, with same-cycle CDB and zero-register readiness folded in.
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.ps1     = disp_ps1;
    new_ent.ps1_rdy = disp_ps1_rdy | (disp_ps1 == '0) | cdb_hit(disp_ps1, cdb_valid, cdb_pd);
    new_ent.ps2     = disp_ps2;
    new_ent.ps2_rdy = disp_ps2_rdy | (disp_ps2 == '0) | cdb_hit(disp_ps2, cdb_valid, cdb_pd);
    new_ent.pd      = disp_pd;
    new_ent.rd      = disp_rd;
    new_ent.rob_idx = disp_rob_idx;
    new_ent.mulop   = mul_f3_t'(disp_mulop);
    new_ent.br_mask = disp_br_mask & ~br_clr;
  end

`ifdef MUL_RS_AGE_EN
  logic [ENTRIES-1:0][ENTRIES-1:0] age;

  // New row marks every resident entry as older; its column is cleared so
  // stale bits left by the slot's previous occupant never make it look old.
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '0;
    end else if (disp_we) begin
      for (int i = 0; i < ENTRIES; i++)
        if (free_oh[i]) age[i] <= vld;
        else            age[i] <= age[i] & ~free_oh;
    end
  end

  mul_rs_select u_sel (
    .req       (req),
    .age       (age),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );
`else
  mul_rs_select u_sel (
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );
`endif

  // Issue payload mux (grant is one-hot).
  always_comb begin
    iss_ps1     = '0;
    iss_ps2     = '0;
    iss_pd      = '0;
    iss_rd      = '0;
    iss_rob_idx = '0;
    iss_mulop   = '0;
    iss_br_mask = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (gnt[i]) begin
        iss_ps1     = ent[i].ps1;
        iss_ps2     = ent[i].ps2;
        iss_pd      = ent[i].pd;
        iss_rd      = ent[i].rd;
        iss_rob_idx = ent[i].rob_idx;
        iss_mulop   = ent[i].mulop;
        iss_br_mask = ent[i].br_mask & ~br_clr;
      end
  end

  assign iss_valid = gnt_valid & ~rst;

  // Entry state: write, free on issue/kill, wakeup, mask clear.
  always_ff @(posedge clk) begin
    if (rst || flush_all) begin
      for (int i = 0; i < ENTRIES; i++) ent[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (disp_we && free_oh[i]) begin
          ent[i] <= new_ent;
        end else begin
          if (gnt[i] || kill[i]) ent[i].valid <= 1'b0;
          if (cdb_hit(ent[i].ps1, cdb_valid, cdb_pd)) ent[i].ps1_rdy <= 1'b1;
          if (cdb_hit(ent[i].ps2, cdb_valid, cdb_pd)) ent[i].ps2_rdy <= 1'b1;
          ent[i].br_mask <= ent[i].br_mask & ~br_clr;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_rs.sv
// Bench for mul_rs: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a slot-level model.
module tb_mul_rs;
  import mul_rs_pkg::*;

`ifdef MUL_RS_AGE_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush_all, disp_valid, disp_ready;
  logic [5:0]  disp_ps1, disp_ps2, disp_pd;
  logic        disp_ps1_rdy, disp_ps2_rdy;
  logic [4:0]  disp_rd, disp_rob_idx;
  logic [2:0]  disp_mulop;
  logic [3:0]  disp_br_mask;
  logic [2:0]  cdb_valid;
  logic [17:0] cdb_pd;
  logic        br_valid, br_mispred;
  logic [1:0]  br_idx;
  logic        iss_valid;
  logic [5:0]  iss_ps1, iss_ps2, iss_pd;
  logic [4:0]  iss_rd, iss_rob_idx;
  logic [2:0]  iss_mulop;
  logic [3:0]  iss_br_mask;

  mul_rs dut (
    .clk(clk), .rst(rst), .flush_all(flush_all),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
    .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
    .disp_pd(disp_pd), .disp_rd(disp_rd), .disp_rob_idx(disp_rob_idx),
    .disp_mulop(disp_mulop), .disp_br_mask(disp_br_mask),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
    .br_valid(br_valid), .br_mispred(br_mispred), .br_idx(br_idx),
    .iss_valid(iss_valid), .iss_ps1(iss_ps1), .iss_ps2(iss_ps2),
    .iss_pd(iss_pd), .iss_rd(iss_rd), .iss_rob_idx(iss_rob_idx),
    .iss_mulop(iss_mulop), .iss_br_mask(iss_br_mask)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit         v;
    logic [5:0] s1, s2, pd;
    bit         r1, r2;
    logic [4:0] rd, rob;
    logic [2:0] op;
    logic [3:0] mask;
    int         seq;
  } ment_t;

  ment_t mst[4];
  ment_t nst[4];
  int    seq_ctr = 0;
  int    pick, free_i;
  bit    exp_rdy;
  bit    kil[4];

  function automatic bit hit(input logic [5:0] t);
    for (int p = 0; p < 3; p++)
      if (cdb_valid[p] && cdb_pd[p*6 +: 6] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Compare DUT against the model mid-cycle, then compute the model's next state.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_disp_ready", disp_ready, 1);
      chk("rst_iss_valid", iss_valid, 0);
    end else begin
      exp_rdy = 1'b0;
      free_i  = -1;
      for (int i = 0; i < 4; i++)
        if (!mst[i].v) begin
          exp_rdy = 1'b1;
          if (free_i < 0) free_i = i;
        end
      pick = -1;
      for (int i = 0; i < 4; i++) begin
        kil[i] = br_valid && br_mispred && mst[i].mask[br_idx];
        if (mst[i].v && mst[i].r1 && mst[i].r2 && !kil[i])
          if (pick < 0 || (AGE && mst[i].seq < mst[pick].seq)) pick = i;
      end
      chk("disp_ready", disp_ready, exp_rdy);
      chk("iss_valid", iss_valid, pick >= 0);
      if (pick >= 0) begin
        chk("iss_ps1", iss_ps1, mst[pick].s1);
        chk("iss_ps2", iss_ps2, mst[pick].s2);
        chk("iss_pd", iss_pd, mst[pick].pd);
        chk("iss_rd", iss_rd, mst[pick].rd);
        chk("iss_rob_idx", iss_rob_idx, mst[pick].rob);
        chk("iss_mulop", iss_mulop, mst[pick].op);
        chk("iss_br_mask", iss_br_mask,
            br_valid ? (mst[pick].mask & ~(4'b1 << br_idx)) : mst[pick].mask);
      end
      nst = mst;
      for (int i = 0; i < 4; i++) begin
        if (flush_all || pick == i || kil[i]) nst[i].v = 1'b0;
        else begin
          if (hit(mst[i].s1)) nst[i].r1 = 1'b1;
          if (hit(mst[i].s2)) nst[i].r2 = 1'b1;
          if (br_valid) nst[i].mask[br_idx] = 1'b0;
        end
      end
      if (!flush_all && disp_valid && exp_rdy &&
          !(br_valid && br_mispred && disp_br_mask[br_idx])) begin
        nst[free_i].v    = 1'b1;
        nst[free_i].s1   = disp_ps1;
        nst[free_i].s2   = disp_ps2;
        nst[free_i].r1   = disp_ps1_rdy || disp_ps1 == 0 || hit(disp_ps1);
        nst[free_i].r2   = disp_ps2_rdy || disp_ps2 == 0 || hit(disp_ps2);
        nst[free_i].pd   = disp_pd;
        nst[free_i].rd   = disp_rd;
        nst[free_i].rob  = disp_rob_idx;
        nst[free_i].op   = disp_mulop;
        nst[free_i].mask = br_valid ? (disp_br_mask & ~(4'b1 << br_idx)) : disp_br_mask;
        nst[free_i].seq  = seq_ctr;
        seq_ctr++;
      end
    end
  end

  // Model state register.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mst[i].v <= 1'b0;
    end else begin
      mst <= nst;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    flush_all = 0; disp_valid = 0;
    disp_ps1 = 0; disp_ps2 = 0; disp_ps1_rdy = 0; disp_ps2_rdy = 0;
    disp_pd = 0; disp_rd = 0; disp_rob_idx = 0; disp_mulop = 0; disp_br_mask = 0;
    cdb_valid = 0; cdb_pd = 0;
    br_valid = 0; br_mispred = 0; br_idx = 0;
  endtask

  task automatic set_disp(input logic [5:0] p1, input bit r1, input logic [5:0] p2,
                          input bit r2, input logic [5:0] pd, input logic [3:0] mask);
    disp_valid = 1; disp_ps1 = p1; disp_ps1_rdy = r1; disp_ps2 = p2; disp_ps2_rdy = r2;
    disp_pd = pd; disp_rd = pd[4:0]; disp_rob_idx = pd[4:0] ^ 5'h1f;
    disp_mulop = {1'b0, pd[1:0]}; disp_br_mask = mask;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    idle();
    if ($urandom_range(0, 99) == 0) flush_all = 1;
    if ($urandom_range(0, 1) == 1)
      set_disp(6'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
               6'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
               6'($urandom_range(0, 63)), 4'($urandom & $urandom));
    for (int p = 0; p < 3; p++)
      if ($urandom_range(0, 9) < 4) begin
        cdb_valid[p] = 1'b1;
        cdb_pd[p*6 +: 6] = 6'($urandom_range(0, 15));
      end
    if ($urandom_range(0, 99) < 15) begin
      br_valid   = 1;
      br_mispred = $urandom_range(0, 9) < 3;
      br_idx     = 2'($urandom_range(0, 3));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;

    // Both sources ready: issues the next cycle, then the slot is gone.
    set_disp(5, 1, 7, 1, 20, 0);
    @(negedge clk); chk("t1_ready", disp_ready, 1); chk("t1_no_iss", iss_valid, 0);
    tick(); idle();
    @(negedge clk); chk("t1_iss", iss_valid, 1); chk("t1_ps1", iss_ps1, 5);
    chk("t1_ps2", iss_ps2, 7); chk("t1_pd", iss_pd, 20);
    tick();
    @(negedge clk); chk("t1_freed", iss_valid, 0);
    tick();

    // Wakeup two cycles after dispatch; issue exactly one cycle after the broadcast.
    set_disp(9, 0, 0, 0, 21, 0);
    tick(); idle();
    @(negedge clk); chk("t2_wait", iss_valid, 0);
    tick();
    cdb_valid = 3'b010; cdb_pd[11:6] = 9;
    @(negedge clk); chk("t2_bcast_cycle", iss_valid, 0);
    tick(); idle();
    @(negedge clk); chk("t2_iss", iss_valid, 1); chk("t2_ps1", iss_ps1, 9);
    tick();
    @(negedge clk); chk("t2_once", iss_valid, 0);
    tick();

    // Same-cycle CDB hit at dispatch makes the entry ready at write.
    set_disp(3, 1, 12, 0, 22, 0);
    cdb_valid = 3'b001; cdb_pd[5:0] = 12;
    tick(); idle();
    @(negedge clk); chk("t3_iss", iss_valid, 1); chk("t3_ps2", iss_ps2, 12);
    tick();

    // Fill the station, 5th dispatch ignored, wake slot 2.
    for (int k = 0; k < 4; k++) begin
      set_disp(6'(30 + k), 0, 1, 1, 6'(40 + k), 0);
      tick();
    end
    set_disp(2, 1, 3, 1, 55, 0);
    @(negedge clk); chk("t4_full", disp_ready, 0); chk("t4_none", iss_valid, 0);
    tick(); idle();
    cdb_valid = 3'b100; cdb_pd[17:12] = 32;
    @(negedge clk); chk("t4_full2", disp_ready, 0);
    tick(); idle();
    @(negedge clk); chk("t4_iss", iss_valid, 1); chk("t4_ps1", iss_ps1, 32);
    chk("t4_still_full", disp_ready, 0);
    tick();
    @(negedge clk); chk("t4_free", disp_ready, 1); chk("t4_5th_dropped", iss_valid, 0);
    tick();
    flush_all = 1;
    tick(); idle();

    // Mispredict on bit 0 kills the first entry; the second keeps mask 0010.
    set_disp(40, 0, 0, 1, 23, 4'b0001); tick();
    set_disp(41, 0, 0, 1, 24, 4'b0010); tick();
    idle();
    br_valid = 1; br_mispred = 1; br_idx = 0;
    cdb_valid = 3'b011; cdb_pd = {6'd0, 6'd41, 6'd40};
    @(negedge clk); chk("t5_kill_no_iss", iss_valid, 0);
    tick(); idle();
    @(negedge clk); chk("t5_iss", iss_valid, 1); chk("t5_ps1", iss_ps1, 41);
    chk("t5_mask", iss_br_mask, 4'b0010);
    tick();
    @(negedge clk); chk("t5_killed_gone", iss_valid, 0);
    tick();

    // Correct prediction clears the mask bit.
    set_disp(42, 0, 0, 1, 25, 4'b0001); tick();
    idle(); br_valid = 1; br_mispred = 0; br_idx = 0; tick();
    idle(); cdb_valid = 3'b001; cdb_pd[5:0] = 42; tick();
    idle();
    @(negedge clk); chk("t5_res_iss", iss_valid, 1); chk("t5_res_mask", iss_br_mask, 4'b0000);
    tick();

    // Killed dispatch completes the handshake but is never written.
    set_disp(2, 1, 3, 1, 26, 4'b0100);
    br_valid = 1; br_mispred = 1; br_idx = 2;
    @(negedge clk); chk("t5_kdisp_hs", disp_ready, 1);
    tick(); idle();
    @(negedge clk); chk("t5_kdisp_dropped", iss_valid, 0);
    tick();

    // A lands in slot 3, later B in slot 0; wake both together.
    for (int k = 0; k < 3; k++) begin
      set_disp(6'(50 + k), 0, 0, 1, 6'(30 + k), 0);
      tick();
    end
    set_disp(60, 0, 0, 1, 33, 0); tick();
    idle(); cdb_valid = 3'b001; cdb_pd[5:0] = 50; tick();
    idle();
    @(negedge clk); chk("t6_slot0", iss_ps1, 50);
    tick();
    set_disp(61, 0, 0, 1, 34, 0); tick();
    idle(); cdb_valid = 3'b011; cdb_pd = {6'd0, 6'd61, 6'd60}; tick();
    idle();
    @(negedge clk);
    chk("t6_first", iss_ps1, AGE ? 32'd60 : 32'd61);
    tick();
    @(negedge clk);
    chk("t6_second", iss_ps1, AGE ? 32'd61 : 32'd60);
    tick();
    flush_all = 1;
    tick(); idle();

    // Randomized traffic against the model.
    repeat (3000) begin
      rand_inputs();
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
